// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared encodings and default widths for the DRAM port arbiter
package dram_arb_pkg;
  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: CPU, DMA and RAM-side signals of the data RAM arbiter
interface dram_port_arbiter_if #(parameter int ADDR_W = 10, parameter int DATA_W = 32);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_lock, dma_addr, dma_wdata, ram_dout,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata, ram_we, ram_addr, ram_din
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_lock, dma_addr, dma_wdata, ram_dout,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, rdata, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating up-counter with synchronous clear (clear wins)
module arb_sat_counter #(
  parameter int          W   = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc && cnt_q != MAX) cnt_q <= cnt_q + 1'b1;
  assign cnt = cnt_q;
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: CPU-priority arbiter for the data RAM with DMA starvation guard and bursts
// Define ARB_STATS_EN to build the CPU-stall and DMA-transfer counters.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 RSTN,
  dram_port_arbiter_if.slave   bus,
  output logic [15:0]          stat_cpu_stall,
  output logic [15:0]          stat_dma_xfer
);
  state_e            state_q, state_d;
  owner_e            rd_owner_q;
  logic              ready_q, rd_pend_q;
  logic [3:0]        burst_cnt_q, burst_cnt_d, burst_inc;
  logic [7:0]        starve_cnt;
  logic              force_dma, cpu_acc, dma_acc;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d, rdata_q;
  always_comb begin
    force_dma   = bus.dma_req && (starve_cnt == 8'(STARVE_LIMIT));
    cpu_acc     = ready_q && bus.cpu_req && !force_dma && state_q == ARB;
    dma_acc     = ready_q && bus.dma_req && !cpu_acc;
    burst_inc   = burst_cnt_q + 4'd1;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == ARB) begin
      if (dma_acc && bus.dma_lock && MAX_BURST > 1) begin
        state_d     = BURST;
        burst_cnt_d = 4'd1;
      end
    end else if (!bus.dma_req || (dma_acc && (!bus.dma_lock || burst_inc == 4'(MAX_BURST)))) begin
      state_d     = ARB;
      burst_cnt_d = '0;
    end else if (dma_acc) begin
      burst_cnt_d = burst_inc;
    end
  end
  // The RAM bus keeps its last address/data when idle so it does not toggle.
  always_comb begin
    ram_addr_d = cpu_acc ? bus.cpu_addr  : dma_acc ? bus.dma_addr  : ram_addr_q;
    ram_din_d  = cpu_acc ? bus.cpu_wdata : dma_acc ? bus.dma_wdata : ram_din_q;
  end
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      state_q     <= ARB;
      burst_cnt_q <= '0;
      ready_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWN_CPU;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      ready_q     <= 1'b1;
      rd_pend_q   <= (cpu_acc && !bus.cpu_we) || (dma_acc && !bus.dma_we);
      rd_owner_q  <= cpu_acc ? OWN_CPU : dma_acc ? OWN_DMA : rd_owner_q;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rdata_q     <= rd_pend_q ? bus.ram_dout : rdata_q;
    end
  arb_sat_counter #(.W(8), .MAX(8'(STARVE_LIMIT))) u_starve (
    .clk(clk), .rst_n(RSTN),
    .clr(dma_acc || !bus.dma_req),
    .inc(bus.dma_req && !dma_acc),
    .cnt(starve_cnt)
  );
  assign bus.cpu_gnt    = cpu_acc;
  assign bus.dma_gnt    = dma_acc;
  assign bus.ram_we     = cpu_acc ? bus.cpu_we : dma_acc && bus.dma_we;
  assign bus.ram_addr   = ram_addr_d;
  assign bus.ram_din    = ram_din_d;
  assign bus.cpu_rvalid = rd_pend_q && rd_owner_q == OWN_CPU;
  assign bus.dma_rvalid = rd_pend_q && rd_owner_q == OWN_DMA;
  assign bus.rdata      = rd_pend_q ? bus.ram_dout : rdata_q;
`ifdef ARB_STATS_EN
  arb_sat_counter #(.W(16)) u_stat_stall (
    .clk(clk), .rst_n(RSTN), .clr(1'b0),
    .inc(bus.cpu_req && !cpu_acc),
    .cnt(stat_cpu_stall)
  );
  arb_sat_counter #(.W(16)) u_stat_xfer (
    .clk(clk), .rst_n(RSTN), .clr(1'b0),
    .inc(dma_acc),
    .cnt(stat_dma_xfer)
  );
`else
  assign stat_cpu_stall = '0;
  assign stat_dma_xfer  = '0;
`endif
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: vector table plus directed sequences for the DRAM port arbiter
module tb_dram_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] st_stall, st_xfer;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dram_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();
  dram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .RSTN(rst_n), .bus(bus), .stat_cpu_stall(st_stall), .stat_dma_xfer(st_xfer)
  );
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end
`ifdef ARB_STATS_EN
  logic rst2_n = 1'b0;
  logic [15:0] s2_stall, s2_xfer;
  dram_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b2 ();
  dram_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(15), .STARVE_LIMIT(1)) dut2 (
    .clk(clk), .RSTN(rst2_n), .bus(b2), .stat_cpu_stall(s2_stall), .stat_dma_xfer(s2_xfer)
  );
`endif
  typedef struct {
    logic cr, cw; logic [9:0] ca; logic [31:0] cd;
    logic dr, dw, dl; logic [9:0] da; logic [31:0] dd;
    logic e_cg, e_dg, e_crv, e_drv, e_we; logic [9:0] e_addr; logic [31:0] e_rdata;
  } vec_t;
  vec_t v [11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    bus.cpu_req = x.cr; bus.cpu_we = x.cw; bus.cpu_addr = x.ca; bus.cpu_wdata = x.cd;
    bus.dma_req = x.dr; bus.dma_we = x.dw; bus.dma_lock = x.dl; bus.dma_addr = x.da; bus.dma_wdata = x.dd;
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_cg"}, 32'(bus.cpu_gnt), 0);
    chk({nm, "_dg"}, 32'(bus.dma_gnt), 0);
    chk({nm, "_crv"}, 32'(bus.cpu_rvalid), 0);
    chk({nm, "_drv"}, 32'(bus.dma_rvalid), 0);
    chk({nm, "_we"}, 32'(bus.ram_we), 0);
    chk({nm, "_addr"}, 32'(bus.ram_addr), 0);
    chk({nm, "_din"}, bus.ram_din, 0);
    chk({nm, "_rdata"}, bus.rdata, 0);
  endtask
  initial begin
    v[0]  = '{1,1,5,32'h12345678, 0,0,0,0,0,            1,0,0,0,1, 5, 32'h0};
    v[1]  = '{1,0,5,0,            0,0,0,0,0,            1,0,0,0,0, 5, 32'h0};
    v[2]  = '{0,0,0,0,            0,0,0,0,0,            0,0,1,0,0, 5, 32'h12345678};
    v[3]  = '{0,0,0,0,            1,1,0,9,32'hA5A5A5A5, 0,1,0,0,1, 9, 32'h12345678};
    v[4]  = '{1,0,5,0,            1,0,0,9,0,            1,0,0,0,0, 5, 32'h12345678};
    v[5]  = '{0,0,0,0,            1,0,0,9,0,            0,1,1,0,0, 9, 32'h12345678};
    v[6]  = '{1,0,9,0,            0,0,0,0,0,            1,0,0,1,0, 9, 32'hA5A5A5A5};
    v[7]  = '{0,0,0,0,            0,0,0,0,0,            0,0,1,0,0, 9, 32'hA5A5A5A5};
    v[8]  = '{0,0,0,0,            1,1,1,2,32'h2,        0,1,0,0,1, 2, 32'hA5A5A5A5};
    v[9]  = '{1,1,3,32'h3,        0,0,0,0,0,            0,0,0,0,0, 2, 32'hA5A5A5A5};
    v[10] = '{1,1,3,32'h3,        0,0,0,0,0,            1,0,0,0,1, 3, 32'hA5A5A5A5};
    drive('{1,1,5,32'h12345678, 0,0,0,0,0, 0,0,0,0,0,0,0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("not_ready_cg", 32'(bus.cpu_gnt), 0);
    @(posedge clk); #1;
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge clk);
      chk($sformatf("v%0d_cg", i), 32'(bus.cpu_gnt), 32'(v[i].e_cg));
      chk($sformatf("v%0d_dg", i), 32'(bus.dma_gnt), 32'(v[i].e_dg));
      chk($sformatf("v%0d_crv", i), 32'(bus.cpu_rvalid), 32'(v[i].e_crv));
      chk($sformatf("v%0d_drv", i), 32'(bus.dma_rvalid), 32'(v[i].e_drv));
      chk($sformatf("v%0d_we", i), 32'(bus.ram_we), 32'(v[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(bus.ram_addr), 32'(v[i].e_addr));
      chk($sformatf("v%0d_rdata", i), bus.rdata, v[i].e_rdata);
      @(posedge clk); #1;
    end
    // sustained CPU writes against a waiting DMA: one forced DMA slot every 9 cycles
    drive('{1,1,7,32'h7, 1,1,0,8,32'h8, 0,0,0,0,0,0,0});
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_cg", i), 32'(bus.cpu_gnt), 32'(i % 9 != 8));
      chk($sformatf("starve%0d_dg", i), 32'(bus.dma_gnt), 32'(i % 9 == 8));
      @(posedge clk); #1;
    end
    bus.dma_lock = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("burst%0d_cg", i), 32'(bus.cpu_gnt), 32'(i < 8 || i > 11));
      chk($sformatf("burst%0d_dg", i), 32'(bus.dma_gnt), 32'(i >= 8 && i <= 11));
      @(posedge clk); #1;
    end
    // DMA read accepted, then reset before the data returns
    drive('{0,0,0,0, 1,0,0,9,0, 0,0,0,0,0,0,0});
    @(negedge clk);
    chk("rstrd_dg", 32'(bus.dma_gnt), 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rstmid");
    bus.dma_req = 1'b0;
    @(posedge clk); #1;
    chk("rstrd_drv", 32'(bus.dma_rvalid), 0);
    chk("rstrd_rdata", bus.rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive('{1,0,9,0, 0,0,0,0,0, 0,0,0,0,0,0,0});
    @(negedge clk);
    chk("post_rst_cg", 32'(bus.cpu_gnt), 1);
    chk("post_rst_addr", 32'(bus.ram_addr), 9);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("post_rst_crv", 32'(bus.cpu_rvalid), 1);
    chk("post_rst_rdata", bus.rdata, 32'hA5A5A5A5);
`ifdef ARB_STATS_EN
    b2.cpu_req = 1'b1; b2.cpu_we = 1'b0; b2.cpu_addr = '0; b2.cpu_wdata = '0;
    b2.dma_req = 1'b1; b2.dma_we = 1'b0; b2.dma_lock = 1'b1; b2.dma_addr = '0; b2.dma_wdata = '0;
    b2.ram_dout = '0;
    @(posedge clk); #1;
    chk("stat_rst_stall", 32'(s2_stall), 0);
    rst2_n = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    chk("stat_stall_20", 32'(s2_stall), 20);
    chk("stat_xfer_19", 32'(s2_xfer), 19);
    repeat (75000) @(posedge clk);
    #1;
    chk("stat_stall_sat", 32'(s2_stall), 32'hFFFF);
    chk("stat_xfer_sat", 32'(s2_xfer), 32'hFFFF);
`else
    chk("stat_stall_off", 32'(st_stall), 0);
    chk("stat_xfer_off", 32'(st_xfer), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-port data RAM (10-bit word address, 32-bit data) between two requesters:
  - the CPU data port, which reaches the RAM through MIO_BUS;
  - a secondary DMA/debug port, used for display refresh and memory dump.
- Sits between MIO_BUS/DMA and RAM_B, and owns ram_we/ram_addr/ram_din.
- CPU has fixed priority, with a starvation guard for DMA. DMA may lock the port for short bursts.

Parameters:
- ADDR_W, 10, RAM word-address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, max consecutive DMA accepts while locked (1..15).
- STARVE_LIMIT, 8, cycles of waiting dma_req that force a DMA grant (1..255).

Ports:
- clk  in  1  system clock; all state on posedge.
- RSTN  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until accepted.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  grant; accept = cpu_req & cpu_gnt.
- cpu_rvalid  out  1  read-data strobe for the CPU.
- dma_req  in  1  DMA request.
- dma_we  in  1  DMA write.
- dma_lock  in  1  keep ownership after this accept (burst).
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA grant.
- dma_rvalid  out  1  read-data strobe for DMA.
- rdata  out  DATA_W  read data, shared by both requesters and qualified by *_rvalid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data, valid one clk after the address is presented.
- stat_cpu_stall  out  16  see Optional Feature.
- stat_dma_xfer  out  16  see Optional Feature.

Behaviour:
- Reset (RSTN low, async):
  - state=ARB; starve_cnt=0; burst_cnt=0; rd_pend=0; rd_owner=0; ready=0.
  - All outputs 0: cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_we, ram_addr, ram_din, rdata.
- ready flop: set on the first clk edge after RSTN rises. Grants are forced 0 while ready=0.
- Grants are combinational from registered state and current requests, giving zero-latency accept.
- State ARB:
  - force = dma_req & (starve_cnt == STARVE_LIMIT).
  - cpu_gnt = ready & cpu_req & ~force.
  - dma_gnt = ready & dma_req & ~cpu_gnt.
  - On DMA accept with dma_lock=1 and MAX_BURST>1: go to BURST, burst_cnt=1.
- State BURST:
  - cpu_gnt=0; dma_gnt = ready & dma_req.
  - Each DMA accept increments burst_cnt.
  - Return to ARB, burst_cnt=0, on any of:
    - an accept with dma_lock=0;
    - an accept making burst_cnt==MAX_BURST;
    - dma_req=0 for one cycle (DMA abandoned the burst).
- starve_cnt:
  - increments each cycle dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT;
  - cleared on any DMA accept, or when dma_req=0.
- RAM drive:
  - accept cycle: ram_addr/ram_din = winner's addr/wdata; ram_we = winner's we.
  - no accept: ram_we=0; ram_addr/ram_din hold their last values (no toggling).
- Read return:
  - an accepted read sets rd_pend=1 and rd_owner=winner.
  - the next cycle: rdata=ram_dout, and the matching *_rvalid pulses for exactly 1 cycle.
  - Back-to-back reads give one rvalid per cycle, latency 1.
  - rdata holds its last value when no rvalid is asserted.
- Writes produce no rvalid.
- Simultaneous cpu_req & dma_req in ARB: CPU wins unless force. Under a sustained CPU stream, DMA therefore gets 1 slot every STARVE_LIMIT+1 cycles.
- Reset mid-burst or with a read pending: both are dropped, no rvalid is issued, and the arbiter restarts in ARB.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - stat_cpu_stall counts cycles with cpu_req=1 & cpu_gnt=0.
  - stat_dma_xfer counts DMA accepts.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- When undefined: both ports are tied 0 and no counter flops are built.

Decomposition:
- Package dram_arb_pkg holds:
  - state encoding ARB=1'b0, BURST=1'b1;
  - owner encoding OWN_CPU=1'b0, OWN_DMA=1'b1;
  - default ADDR_W/DATA_W.
- One natural sub-module: arb_sat_counter, a parameterised-width saturating counter with inc/clear. It is reused for starve_cnt and the two stat counters.

Test Plan:
- Reset release, with cpu_req=1 held through RSTN rise: cpu_gnt stays 0 on the first edge and goes 1 after ready sets. Write of 0x12345678 to addr 5 yields ram_we=1, ram_addr=5.
- CPU read of addr 5, one cycle after the write: cpu_rvalid pulses 1 cycle later with rdata=0x12345678; dma_rvalid=0.
- cpu_req and dma_req both held high, STARVE_LIMIT=8: CPU accepted 8 cycles, DMA accepted on the 9th, then the pattern repeats.
- DMA burst with dma_lock=1, cpu_req=1 throughout, MAX_BURST=4: exactly 4 consecutive DMA accepts, then cpu_gnt=1 on the next cycle.
- DMA read accepted, then RSTN pulsed low before the next edge: no dma_rvalid; all outputs 0 during reset.
- With ARB_STATS_EN: 20 cycles of CPU blocked by a DMA burst gives the matching stat_cpu_stall count; forcing 70000 stalls leaves the counter at 0xFFFF.
